calc_seq_responder: RTL

//  Clocked, handshaked calculator engine: the responder side of the calculator op

---
 rtl/calc_pkg.sv | 20 ++
 rtl/calc_iter_unit.sv | 101 ++++++++++
 rtl/calc_seq_responder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator responder: op encodings, FSM states
// and the default operand width.
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Shared iterative datapath: shift-add multiply and restoring divide, one bit
// per cycle, WIDTH iterations. start_i loads operands; done_o is high during
// the cycle whose clock edge performs the last iteration, and the result
// outputs show the values that edge will store.
module calc_iter_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o,
    output logic [WIDTH-1:0]   quotient_o,
    output logic [WIDTH-1:0]   remainder_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // mul: a_q = multiplicand (shifts left), b_q = multiplier (shifts right), acc_q = product
    // div: a_q[WIDTH-1:0] = dividend shifting out / quotient shifting in, b_q = divisor,
    //      acc_q[WIDTH-1:0] = partial remainder
    logic               busy_q, busy_d;
    logic               is_div_q, is_div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic               q_bit;

    // Next-state logic: load on start, otherwise one multiply or divide step while busy
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        busy_d    = busy_q;
        is_div_d  = is_div_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        rem_shift = {acc_q[WIDTH-1:0], a_q[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, b_q};
        q_bit     = (rem_shift >= {1'b0, b_q});

        if (start_i) begin
            busy_d   = 1'b1;
            is_div_d = is_div_i;
            cnt_d    = '0;
            a_d      = {{WIDTH{1'b0}}, a_i};
            b_d      = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
            if (is_div_q) begin
                // Restoring step: keep the trial subtraction only when it does not go negative
                a_d   = {a_q[2*WIDTH-2:0], q_bit};
                acc_d = {{WIDTH{1'b0}}, (q_bit ? rem_trial[WIDTH-1:0] : rem_shift[WIDTH-1:0])};
            end else begin
                acc_d = acc_q + (b_q[0] ? a_q : '0);
                a_d   = {a_q[2*WIDTH-2:0], 1'b0};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
            end
        end
    end

    // State registers for the iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            busy_q   <= busy_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
        end
    end

    assign done_o      = busy_q && (cnt_q == LAST);
    assign product_o   = acc_d;
    assign quotient_o  = a_d[WIDTH-1:0];
    assign remainder_o = acc_d[WIDTH-1:0];

endmodule

// File: rtl/calc_seq_responder.sv
// Handshaked calculator engine (responder side). Add/sub and divide-by-zero
// answer one cycle after accept; multiply/divide iterate WIDTH cycles in
// calc_iter_unit. FSM IDLE -> EXEC -> DONE -> IDLE with registered outputs.
// Optional feature: define CALC_ERR_STICKY_EN to add the err_sticky output,
// set on any divide by zero and cleared only by reset.
module calc_seq_responder
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [1:0]         req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic [WIDTH-1:0]   rsp_remainder,
`ifdef CALC_ERR_STICKY_EN
    output logic               err_sticky,
`endif
    output logic               rsp_error
);

    state_e             state_q;
    op_e                op_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [2*WIDTH-1:0] result_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               error_q;

    op_e                req_op_e;
    logic               accept;
    logic               b_zero;
    logic               iter_start;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    logic               iter_done;
    logic [2*WIDTH-1:0] iter_product;
    logic [WIDTH-1:0]   iter_quotient;
    logic [WIDTH-1:0]   iter_remainder;

    assign req_op_e   = op_e'(req_op);
    assign accept     = req_valid && req_ready_q;
    assign b_zero     = (req_b == '0);
    assign iter_start = accept && ((req_op_e == OP_MUL) || ((req_op_e == OP_DIV) && !b_zero));
    assign a_ext      = {{WIDTH{1'b0}}, req_a};
    assign b_ext      = {{WIDTH{1'b0}}, req_b};

    calc_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (iter_start),
        .is_div_i    (req_op_e == OP_DIV),
        .a_i         (req_a),
        .b_i         (req_b),
        .done_o      (iter_done),
        .product_o   (iter_product),
        .quotient_o  (iter_quotient),
        .remainder_o (iter_remainder)
    );

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q        <= req_op_e;
                        req_ready_q <= 1'b0;
                        remainder_q <= '0;
                        error_q     <= 1'b0;
                        case (req_op_e)
                            OP_ADD: begin
                                result_q    <= a_ext + b_ext;
                                rsp_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            OP_SUB: begin
                                result_q    <= a_ext - b_ext;
                                rsp_valid_q <= 1'b1;
                                state_q     <= DONE;
                            end
                            OP_MUL: begin
                                state_q <= EXEC;
                            end
                            OP_DIV: begin
                                if (b_zero) begin
                                    result_q    <= '0;
                                    error_q     <= 1'b1;
                                    rsp_valid_q <= 1'b1;
                                    state_q     <= DONE;
                                end else begin
                                    state_q <= EXEC;
                                end
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (iter_done) begin
                        if (op_q == OP_DIV) begin
                            result_q    <= {{WIDTH{1'b0}}, iter_quotient};
                            remainder_q <= iter_remainder;
                        end else begin
                            result_q    <= iter_product;
                            remainder_q <= '0;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // Response held until consumed; req_ready returns one cycle later
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef CALC_ERR_STICKY_EN
    logic err_sticky_q;

    // Sticky divide-by-zero flag, independent of the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
        end else if (accept && (req_op_e == OP_DIV) && b_zero) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = result_q;
    assign rsp_remainder = remainder_q;
    assign rsp_error     = error_q;

endmodule
